// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   hz_state_e  : controller FSM states (RUN / LSTALL / MWAIT)
//   sel_width   : width of a forward select able to encode 0..stages
//   need_width  : width of a stall-cycle count able to hold 0..lat+1
package pipe_hazard_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_MWAIT  = 2'd2
  } hz_state_e;

  function automatic int unsigned sel_width(input int unsigned stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

  function automatic int unsigned need_width(input int unsigned lat);
    return $clog2(lat + 2);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_select.sv
// fwd_select: per-operand priority comparator.
// Finds the nearest producer stage writing the source register and reports
// how many stall cycles are needed when that producer is an unfinished load.
//   src        in  REG_AW              source register of the ID instruction
//   use_src    in  1                   the instruction actually reads src
//   id_valid   in  1                   ID holds a real instruction
//   stg_wn     in  FWD_STAGES*REG_AW   destination per stage, stage k in slice k-1
//   stg_wreg   in  FWD_STAGES          stage k writes a register
//   stg_m2reg  in  FWD_STAGES          stage k is a load
//   sel        out SEL_W               0 = regfile, k = forward from stage k
//   need       out NEED_W              load-use stall cycles required (0 = none)
module fwd_select
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned SEL_W      = sel_width(FWD_STAGES),
  parameter int unsigned NEED_W     = need_width(LOAD_LAT)
) (
  input  logic [REG_AW-1:0]            src,
  input  logic                         use_src,
  input  logic                         id_valid,
  input  logic [FWD_STAGES*REG_AW-1:0] stg_wn,
  input  logic [FWD_STAGES-1:0]        stg_wreg,
  input  logic [FWD_STAGES-1:0]        stg_m2reg,
  output logic [SEL_W-1:0]             sel,
  output logic [NEED_W-1:0]            need
);

  logic              hit_load;
  logic [NEED_W-1:0] hit_need;

  // Scan from the farthest stage (WB) towards EXE so the nearest match is the
  // last assignment and therefore wins.
  always_comb begin
    sel      = '0;
    hit_load = 1'b0;
    hit_need = '0;
    for (int unsigned i = 0; i < FWD_STAGES; i++) begin
      if (use_src && (src != '0) && stg_wreg[FWD_STAGES-1-i] &&
          (stg_wn[(FWD_STAGES-1-i)*REG_AW +: REG_AW] == src)) begin
        sel      = SEL_W'(FWD_STAGES - i);
        hit_load = stg_m2reg[FWD_STAGES-1-i] && ((FWD_STAGES - i) <= LOAD_LAT);
        hit_need = NEED_W'(LOAD_LAT + 1 - (FWD_STAGES - i));
      end
    end
  end

  assign need = (hit_load && id_valid) ? hit_need : '0;

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard, forwarding and stall controller for the pipelined
// CPU. Forwarding, stall and flush decisions are combinational; only the FSM
// state, the remaining stall count and the event counters are registered.
//   Clock       in  1                  rising-edge clock
//   Resetn      in  1                  asynchronous active-low reset
//   id_valid    in  1                  ID holds a real instruction
//   id_rs/id_rt in  REG_AW             ID source registers
//   id_use_rs/t in  1                  ID instruction reads rs / rt
//   stg_wn      in  FWD_STAGES*REG_AW  destination per stage (stage k in slice k-1)
//   stg_wreg    in  FWD_STAGES         stage k writes a register
//   stg_m2reg   in  FWD_STAGES         stage k is a load
//   br_taken    in  1                  branch/jump in ID resolved taken
//   mem_req     in  1                  MEM stage accesses data memory
//   mem_ready   in  1                  data memory completes this cycle
//   fwd_a/fwd_b out SEL_W              operand source: 0 = regfile, k = stage k
//   stall_if    out 1                  hold the PC
//   stall_id    out 1                  hold the IF/ID link
//   bubble_exe  out 1                  zero control into the ID/EXE link
//   flush_id    out 1                  squash the fetched instruction
//   freeze      out 1                  hold every link and the PC (memory wait)
//   cnt_stall   out CNT_W              saturating count of load-use bubble cycles
//   cnt_flush   out CNT_W              saturating count of branch flushes
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter  int unsigned REG_AW     = 5,
  parameter  int unsigned FWD_STAGES = 3,
  parameter  int unsigned LOAD_LAT   = 1,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned SEL_W      = sel_width(FWD_STAGES)
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic                         id_valid,
  input  logic [REG_AW-1:0]            id_rs,
  input  logic [REG_AW-1:0]            id_rt,
  input  logic                         id_use_rs,
  input  logic                         id_use_rt,
  input  logic [FWD_STAGES*REG_AW-1:0] stg_wn,
  input  logic [FWD_STAGES-1:0]        stg_wreg,
  input  logic [FWD_STAGES-1:0]        stg_m2reg,
  input  logic                         br_taken,
  input  logic                         mem_req,
  input  logic                         mem_ready,
  output logic [SEL_W-1:0]             fwd_a,
  output logic [SEL_W-1:0]             fwd_b,
  output logic                         stall_if,
  output logic                         stall_id,
  output logic                         bubble_exe,
  output logic                         flush_id,
  output logic                         freeze,
  output logic [CNT_W-1:0]             cnt_stall,
  output logic [CNT_W-1:0]             cnt_flush
);

  localparam int unsigned NEED_W = need_width(LOAD_LAT);

  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic [NEED_W-1:0] need_a;
  logic [NEED_W-1:0] need_b;
  logic [NEED_W-1:0] need;
  logic              hazard;
  logic              mem_wait;

  hz_state_e         state_q, state_d;
  hz_state_e         saved_state_q, saved_state_d;
  logic [NEED_W-1:0] cnt_q, cnt_d;
  logic [NEED_W-1:0] saved_cnt_q, saved_cnt_d;
  logic [CNT_W-1:0]  cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0]  cnt_flush_q, cnt_flush_d;

  hz_state_e         eff_state;
  logic [NEED_W-1:0] eff_cnt;

  fwd_select #(
    .REG_AW     (REG_AW),
    .FWD_STAGES (FWD_STAGES),
    .LOAD_LAT   (LOAD_LAT),
    .SEL_W      (SEL_W),
    .NEED_W     (NEED_W)
  ) u_fwd_a (
    .src       (id_rs),
    .use_src   (id_use_rs),
    .id_valid  (id_valid),
    .stg_wn    (stg_wn),
    .stg_wreg  (stg_wreg),
    .stg_m2reg (stg_m2reg),
    .sel       (sel_a),
    .need      (need_a)
  );

  fwd_select #(
    .REG_AW     (REG_AW),
    .FWD_STAGES (FWD_STAGES),
    .LOAD_LAT   (LOAD_LAT),
    .SEL_W      (SEL_W),
    .NEED_W     (NEED_W)
  ) u_fwd_b (
    .src       (id_rt),
    .use_src   (id_use_rt),
    .id_valid  (id_valid),
    .stg_wn    (stg_wn),
    .stg_wreg  (stg_wreg),
    .stg_m2reg (stg_m2reg),
    .sel       (sel_b),
    .need      (need_b)
  );

  assign need     = (need_a > need_b) ? need_a : need_b;
  assign hazard   = (need != '0);
  assign mem_wait = mem_req && !mem_ready;

  // The cycle in which memory completes behaves as the interrupted state, so
  // a stall split by a memory wait still totals the same number of cycles.
  always_comb begin
    eff_state = state_q;
    eff_cnt   = cnt_q;
    if (state_q == ST_MWAIT) begin
      eff_state = saved_state_q;
      eff_cnt   = saved_cnt_q;
    end
  end

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= ST_RUN;
      saved_state_q <= ST_RUN;
      cnt_q         <= '0;
      saved_cnt_q   <= '0;
      cnt_stall_q   <= '0;
      cnt_flush_q   <= '0;
    end else begin
      state_q       <= state_d;
      saved_state_q <= saved_state_d;
      cnt_q         <= cnt_d;
      saved_cnt_q   <= saved_cnt_d;
      cnt_stall_q   <= cnt_stall_d;
      cnt_flush_q   <= cnt_flush_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    if (mem_wait) begin
      state_d = ST_MWAIT;
      if (state_q != ST_MWAIT) begin
        saved_state_d = state_q;
        saved_cnt_d   = cnt_q;
      end
    end else begin
      case (eff_state)
        ST_LSTALL: begin
          cnt_d   = eff_cnt - 1'b1;
          state_d = (eff_cnt == NEED_W'(1)) ? ST_RUN : ST_LSTALL;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = eff_cnt;
          if (hazard) begin
            cnt_d = need - 1'b1;
            if (need > NEED_W'(1)) begin
              state_d = ST_LSTALL;
            end
          end
        end
      endcase
    end
  end

  // Output logic; everything is forced low while reset is asserted.
  always_comb begin
    fwd_a      = '0;
    fwd_b      = '0;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_exe = 1'b0;
    flush_id   = 1'b0;
    freeze     = 1'b0;
    if (Resetn) begin
      if (mem_wait) begin
        freeze = 1'b1;
      end else begin
        fwd_a = sel_a;
        fwd_b = sel_b;
        if ((eff_state == ST_LSTALL) || ((eff_state == ST_RUN) && hazard)) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          bubble_exe = 1'b1;
        end
        flush_id = (eff_state == ST_RUN) && !hazard && br_taken && id_valid;
      end
    end
  end

  // Saturating event counters
  always_comb begin
    cnt_stall_d = cnt_stall_q;
    cnt_flush_d = cnt_flush_q;
    if (bubble_exe && !(&cnt_stall_q)) begin
      cnt_stall_d = cnt_stall_q + 1'b1;
    end
    if (flush_id && !(&cnt_flush_q)) begin
      cnt_flush_d = cnt_flush_q + 1'b1;
    end
  end

  assign cnt_stall = cnt_stall_q;
  assign cnt_flush = cnt_flush_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic [14:0] wn;
    logic [2:0]  wreg;
    logic [2:0]  m2;
    logic        br;
    logic        mreq;
    logic        mrdy;
  } stim_t;

  typedef struct {
    logic [8:0] v;
    bit         d2;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic [14:0] stg_wn;
  logic [2:0]  stg_wreg, stg_m2reg;
  logic        br_taken, mem_req, mem_ready;

  // dut1: LOAD_LAT=1 with 3-bit counters (saturation reachable); dut2: LOAD_LAT=2
  logic [1:0]  fa1, fb1, fa2, fb2;
  logic        sif1, sid1, bub1, fl1, fz1;
  logic        sif2, sid2, bub2, fl2, fz2;
  logic [2:0]  cs1, cf1;
  logic [31:0] cs2, cf2;
  logic [8:0]  obs1, obs2;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clock = ~Clock;

  assign obs1 = {fa1, fb1, sif1, sid1, bub1, fl1, fz1};
  assign obs2 = {fa2, fb2, sif2, sid2, bub2, fl2, fz2};

  pipe_hazard_unit #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(1), .CNT_W(3)) u_dut1 (
    .Clock(Clock), .Resetn(Resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .stg_wn(stg_wn), .stg_wreg(stg_wreg),
    .stg_m2reg(stg_m2reg), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .fwd_a(fa1), .fwd_b(fb1), .stall_if(sif1), .stall_id(sid1), .bubble_exe(bub1),
    .flush_id(fl1), .freeze(fz1), .cnt_stall(cs1), .cnt_flush(cf1)
  );

  pipe_hazard_unit #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(32)) u_dut2 (
    .Clock(Clock), .Resetn(Resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .stg_wn(stg_wn), .stg_wreg(stg_wreg),
    .stg_m2reg(stg_m2reg), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .fwd_a(fa2), .fwd_b(fb2), .stall_if(sif2), .stall_id(sid2), .bubble_exe(bub2),
    .flush_id(fl2), .freeze(fz2), .cnt_stall(cs2), .cnt_flush(cf2)
  );

  function automatic logic [14:0] w3(input int wb, input int mem, input int exe);
    return {5'(wb), 5'(mem), 5'(exe)};
  endfunction

  function automatic stim_t mk(input int valid, input int rs, input int rt, input int urs,
                               input int urt, input logic [14:0] wn, input int wreg,
                               input int m2, input int br, input int mreq, input int mrdy);
    stim_t s;
    s.valid = 1'(valid); s.rs = 5'(rs); s.rt = 5'(rt); s.urs = 1'(urs); s.urt = 1'(urt);
    s.wn = wn; s.wreg = 3'(wreg); s.m2 = 3'(m2);
    s.br = 1'(br); s.mreq = 1'(mreq); s.mrdy = 1'(mrdy);
    return s;
  endfunction

  // expected {fwd_a, fwd_b, stall_if, stall_id, bubble_exe, flush_id, freeze}
  function automatic logic [8:0] ex(input int fa, input int fb, input int st,
                                    input int fl, input int fz);
    return {2'(fa), 2'(fb), 1'(st), 1'(st), 1'(st), 1'(fl), 1'(fz)};
  endfunction

  task automatic drive(input stim_t s);
    id_valid  = s.valid; id_rs = s.rs; id_rt = s.rt;
    id_use_rs = s.urs;   id_use_rt = s.urt;
    stg_wn    = s.wn;    stg_wreg = s.wreg; stg_m2reg = s.m2;
    br_taken  = s.br;    mem_req = s.mreq;  mem_ready = s.mrdy;
  endtask

  task automatic do_reset();
    @(posedge Clock); #1;
    Resetn = 1'b0;
    drive(mk(0, 0, 0, 0, 0, w3(0, 0, 0), 0, 0, 0, 0, 0));
    @(posedge Clock); #1;
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    drive(mk(1, 3, 3, 1, 1, w3(0, 0, 3), 'b001, 0, 1, 1, 0));
    #3;
    n_cmp++;
    if (obs1 !== 9'd0) begin n_bad++; $display("FAIL reset_out1: got %b want %b", obs1, 9'd0); end
    n_cmp++;
    if (obs2 !== 9'd0) begin n_bad++; $display("FAIL reset_out2: got %b want %b", obs2, 9'd0); end
    n_cmp++;
    if ({cs1, cf1} !== 6'd0 || {cs2, cf2} !== 64'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0", cs1, cf1, cs2, cf2);
    end
  endtask

  task automatic test_forward();
    stim_t s[6]; logic [8:0] e[6]; exp_t got; logic [8:0] obs;
    do_reset();
    s[0] = mk(1, 3, 4, 1, 1, w3(0, 3, 3), 'b011, 0, 0, 0, 0); e[0] = ex(1, 0, 0, 0, 0);
    s[1] = mk(1, 3, 3, 1, 1, w3(3, 3, 9), 'b111, 0, 0, 0, 0); e[1] = ex(2, 2, 0, 0, 0);
    s[2] = mk(1, 3, 6, 1, 1, w3(6, 3, 3), 'b100, 0, 0, 0, 0); e[2] = ex(0, 3, 0, 0, 0);
    s[3] = mk(1, 3, 3, 0, 1, w3(3, 3, 3), 'b111, 0, 0, 0, 0); e[3] = ex(0, 1, 0, 0, 0);
    s[4] = mk(1, 0, 0, 1, 1, w3(0, 0, 0), 'b111, 0, 0, 0, 0); e[4] = ex(0, 0, 0, 0, 0);
    s[5] = mk(0, 3, 0, 1, 0, w3(0, 0, 3), 'b001, 0, 0, 0, 0); e[5] = ex(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      drive(s[i]); sb.push_back('{v: e[i], d2: 1'b0});
      @(negedge Clock);
      got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
      n_cmp++;
      if (obs !== got.v) begin n_bad++; $display("FAIL forward[%0d]: got %b want %b", i, obs, got.v); end
    end
  endtask

  task automatic test_load_use();
    stim_t s[4]; logic [8:0] e[4]; exp_t got; logic [8:0] obs;
    do_reset();
    s[0] = mk(1, 0, 5, 0, 1, w3(0, 0, 5), 'b001, 'b001, 0, 0, 0); e[0] = ex(0, 1, 1, 0, 0);
    s[1] = mk(1, 0, 5, 0, 1, w3(0, 5, 0), 'b010, 'b010, 0, 0, 0); e[1] = ex(0, 2, 0, 0, 0);
    s[2] = mk(0, 0, 5, 0, 1, w3(0, 0, 5), 'b001, 'b001, 0, 0, 0); e[2] = ex(0, 1, 0, 0, 0);
    s[3] = mk(1, 0, 5, 0, 0, w3(0, 0, 5), 'b001, 'b001, 0, 0, 0); e[3] = ex(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      drive(s[i]); sb.push_back('{v: e[i], d2: 1'b0});
      @(negedge Clock);
      got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
      n_cmp++;
      if (obs !== got.v) begin n_bad++; $display("FAIL load_use[%0d]: got %b want %b", i, obs, got.v); end
    end
    @(posedge Clock); #1;
    n_cmp++;
    if (cs1 !== 3'd1) begin n_bad++; $display("FAIL load_use_cnt: got %0d want 1", cs1); end
  endtask

  task automatic test_load_lat2();
    stim_t s[3]; logic [8:0] e[3]; exp_t got; logic [8:0] obs;
    do_reset();
    s[0] = mk(1, 7, 0, 1, 0, w3(0, 0, 7), 'b001, 'b001, 0, 0, 0); e[0] = ex(1, 0, 1, 0, 0);
    s[1] = mk(1, 7, 0, 1, 0, w3(0, 7, 0), 'b010, 'b010, 0, 0, 0); e[1] = ex(2, 0, 1, 0, 0);
    s[2] = mk(1, 7, 0, 1, 0, w3(7, 0, 0), 'b100, 'b100, 0, 0, 0); e[2] = ex(3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      drive(s[i]); sb.push_back('{v: e[i], d2: 1'b1});
      @(negedge Clock);
      got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
      n_cmp++;
      if (obs !== got.v) begin n_bad++; $display("FAIL lat2[%0d]: got %b want %b", i, obs, got.v); end
    end
    @(posedge Clock); #1;
    n_cmp++;
    if (cs2 !== 32'd2) begin n_bad++; $display("FAIL lat2_cnt: got %0d want 2", cs2); end
  endtask

  task automatic test_load_in_mem();
    stim_t s[2]; logic [8:0] e[2]; exp_t got; logic [8:0] obs;
    do_reset();
    s[0] = mk(1, 7, 0, 1, 0, w3(0, 7, 9), 'b011, 'b010, 0, 0, 0); e[0] = ex(2, 0, 1, 0, 0);
    s[1] = mk(1, 7, 0, 1, 0, w3(7, 9, 0), 'b110, 'b100, 0, 0, 0); e[1] = ex(3, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #1;
      drive(s[i]); sb.push_back('{v: e[i], d2: 1'b1});
      @(negedge Clock);
      got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
      n_cmp++;
      if (obs !== got.v) begin n_bad++; $display("FAIL load_mem[%0d]: got %b want %b", i, obs, got.v); end
    end
    @(posedge Clock); #1;
    n_cmp++;
    if (cs2 !== 32'd1) begin n_bad++; $display("FAIL load_mem_cnt: got %0d want 1", cs2); end
  endtask

  task automatic test_max_need();
    stim_t s[3]; logic [8:0] e[3]; exp_t got; logic [8:0] obs;
    do_reset();
    s[0] = mk(1, 7, 8, 1, 1, w3(0, 8, 7), 'b011, 'b011, 0, 0, 0); e[0] = ex(1, 2, 1, 0, 0);
    s[1] = mk(1, 7, 8, 1, 1, w3(8, 7, 0), 'b110, 'b110, 0, 0, 0); e[1] = ex(2, 3, 1, 0, 0);
    s[2] = mk(1, 7, 8, 1, 1, w3(7, 0, 0), 'b100, 'b100, 0, 0, 0); e[2] = ex(3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      drive(s[i]); sb.push_back('{v: e[i], d2: 1'b1});
      @(negedge Clock);
      got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
      n_cmp++;
      if (obs !== got.v) begin n_bad++; $display("FAIL max_need[%0d]: got %b want %b", i, obs, got.v); end
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[6]; logic [8:0] e[6]; exp_t got; logic [8:0] obs;
    do_reset();
    s[0] = mk(1, 7, 0, 1, 0, w3(0, 0, 7), 'b001, 'b001, 0, 0, 0); e[0] = ex(1, 0, 1, 0, 0);
    s[1] = mk(1, 7, 0, 1, 0, w3(0, 7, 0), 'b010, 'b010, 0, 1, 0); e[1] = ex(0, 0, 0, 0, 1);
    s[2] = mk(1, 7, 0, 1, 0, w3(0, 7, 0), 'b010, 'b010, 1, 1, 0); e[2] = ex(0, 0, 0, 0, 1);
    s[3] = mk(1, 7, 0, 1, 0, w3(0, 7, 0), 'b010, 'b010, 0, 1, 0); e[3] = ex(0, 0, 0, 0, 1);
    s[4] = mk(1, 7, 0, 1, 0, w3(0, 7, 0), 'b010, 'b010, 0, 1, 1); e[4] = ex(2, 0, 1, 0, 0);
    s[5] = mk(1, 7, 0, 1, 0, w3(7, 0, 0), 'b100, 'b100, 0, 0, 0); e[5] = ex(3, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      drive(s[i]); sb.push_back('{v: e[i], d2: 1'b1});
      @(negedge Clock);
      got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
      n_cmp++;
      if (obs !== got.v) begin n_bad++; $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, got.v); end
    end
    @(posedge Clock); #1;
    n_cmp++;
    if (cs2 !== 32'd2) begin n_bad++; $display("FAIL mem_wait_cnt: got %0d want 2", cs2); end
  endtask

  task automatic test_branch();
    stim_t s[6]; logic [8:0] e[6]; exp_t got; logic [8:0] obs;
    do_reset();
    s[0] = mk(1, 0, 0, 0, 0, w3(0, 0, 0), 0, 0, 1, 0, 0);                 e[0] = ex(0, 0, 0, 1, 0);
    s[1] = mk(1, 0, 0, 0, 0, w3(0, 0, 0), 0, 0, 0, 0, 0);                 e[1] = ex(0, 0, 0, 0, 0);
    s[2] = mk(0, 0, 0, 0, 0, w3(0, 0, 0), 0, 0, 1, 0, 0);                 e[2] = ex(0, 0, 0, 0, 0);
    s[3] = mk(1, 0, 5, 0, 1, w3(0, 0, 5), 'b001, 'b001, 1, 0, 0);         e[3] = ex(0, 1, 1, 0, 0);
    s[4] = mk(1, 0, 5, 0, 1, w3(0, 5, 0), 'b010, 'b010, 1, 0, 0);         e[4] = ex(0, 2, 0, 1, 0);
    s[5] = mk(1, 0, 0, 0, 0, w3(0, 0, 0), 0, 0, 1, 1, 0);                 e[5] = ex(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      drive(s[i]); sb.push_back('{v: e[i], d2: 1'b0});
      @(negedge Clock);
      got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
      n_cmp++;
      if (obs !== got.v) begin n_bad++; $display("FAIL branch[%0d]: got %b want %b", i, obs, got.v); end
    end
    @(posedge Clock); #1;
    n_cmp++;
    if (cf1 !== 3'd2 || cs1 !== 3'd1) begin
      n_bad++; $display("FAIL branch_cnt: got flush %0d stall %0d want flush 2 stall 1", cf1, cs1);
    end
  endtask

  task automatic test_saturation();
    exp_t got; logic [8:0] obs;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge Clock); #1;
      drive(mk(1, 0, 0, 0, 0, w3(0, 0, 0), 0, 0, 1, 0, 0));
      sb.push_back('{v: ex(0, 0, 0, 1, 0), d2: 1'b0});
      @(negedge Clock);
      got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
      n_cmp++;
      if (obs !== got.v) begin n_bad++; $display("FAIL sat[%0d]: got %b want %b", i, obs, got.v); end
    end
    @(posedge Clock); #1;
    n_cmp++;
    if (cf1 !== 3'd7) begin n_bad++; $display("FAIL sat_cnt: got %0d want 7", cf1); end
  endtask

  task automatic test_reset_mid_wait();
    exp_t got; logic [8:0] obs;
    do_reset();
    @(posedge Clock); #1;
    drive(mk(1, 7, 0, 1, 0, w3(0, 0, 7), 'b001, 'b001, 0, 0, 0));
    sb.push_back('{v: ex(1, 0, 1, 0, 0), d2: 1'b1});
    @(negedge Clock);
    got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
    n_cmp++;
    if (obs !== got.v) begin n_bad++; $display("FAIL rmw_stall: got %b want %b", obs, got.v); end
    @(posedge Clock); #1;
    drive(mk(1, 7, 0, 1, 0, w3(0, 7, 0), 'b010, 'b010, 1, 1, 0));
    sb.push_back('{v: ex(0, 0, 0, 0, 1), d2: 1'b1});
    @(negedge Clock);
    got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
    n_cmp++;
    if (obs !== got.v) begin n_bad++; $display("FAIL rmw_freeze: got %b want %b", obs, got.v); end
    @(posedge Clock); #1;
    Resetn = 1'b0;
    #1;
    n_cmp++;
    if (obs2 !== 9'd0 || obs1 !== 9'd0) begin
      n_bad++; $display("FAIL rmw_reset_out: got %b %b want 0", obs1, obs2);
    end
    n_cmp++;
    if (cs2 !== 32'd0) begin n_bad++; $display("FAIL rmw_reset_cnt: got %0d want 0", cs2); end
    @(posedge Clock); #1;
    Resetn = 1'b1;
    drive(mk(1, 0, 0, 1, 1, w3(0, 0, 0), 'b111, 0, 0, 0, 0));
    sb.push_back('{v: ex(0, 0, 0, 0, 0), d2: 1'b1});
    @(negedge Clock);
    got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
    n_cmp++;
    if (obs !== got.v) begin n_bad++; $display("FAIL rmw_r0: got %b want %b", obs, got.v); end
    @(posedge Clock); #1;
    drive(mk(1, 7, 0, 1, 0, w3(7, 0, 0), 'b100, 0, 0, 0, 0));
    sb.push_back('{v: ex(3, 0, 0, 0, 0), d2: 1'b1});
    @(negedge Clock);
    got = sb.pop_front(); obs = got.d2 ? obs2 : obs1;
    n_cmp++;
    if (obs !== got.v) begin n_bad++; $display("FAIL rmw_run: got %b want %b", obs, got.v); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_load_lat2();
    test_load_in_mem();
    test_max_need();
    test_mem_wait();
    test_branch();
    test_saturation();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
